// File: rtl/display_pkg.sv
// Shared display constants and the slot index type used by the scan
// sequencer and the anode controller.
package display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;

  // Digit slot index; wide enough for NUM_DIGITS slots.
  typedef logic [1:0] slot_idx_t;

  // Extract one BCD nibble from a packed digit word.
  function automatic logic [DIGIT_W-1:0] get_nibble(
    input logic [NUM_DIGITS*DIGIT_W-1:0] digits,
    input slot_idx_t                     slot
  );
    return digits[slot*DIGIT_W +: DIGIT_W];
  endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// Divides clk down to one tick per digit slot. The count is held at zero
// while enable is low, so a resumed scan always gets a full slot interval.
module refresh_prescaler #(
  parameter int PRESCALE = 100000  // must be >= 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int            CW   = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_count;

  assign tick = enable && (r_count == LAST);

  // Free-running slot counter, cleared on wrap or whenever the scan is frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (!enable || (r_count == LAST)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/display_scan_sequencer.sv
// Four-digit multiplexed display scan sequencer. New digit data is staged
// in a pending register and only swapped in at a frame boundary, so a frame
// never shows a mix of old and new digits.
// Optional build macro: LEADING_ZERO_BLANK_EN enables leading-zero blanking.
module display_scan_sequencer
  import display_pkg::*;
#(
  parameter int PRESCALE = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] digits_in,
  input  logic        load_req,
  output logic        load_ack,
  output logic [1:0]  refreshcounter,
  output logic [3:0]  digit_out,
  output logic        blank,
  output logic        frame_done
);

  localparam slot_idx_t LAST_SLOT = slot_idx_t'(NUM_DIGITS - 1);

  logic        w_tick;
  logic        w_boundary;
  slot_idx_t   r_refresh;
  logic [15:0] r_active;
  logic [15:0] r_pending;
  logic        r_pending_valid;
  logic        r_load_ack;
  logic        r_frame_done;

  refresh_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .tick   (w_tick)
  );

  // The last tick of slot 3 closes the frame.
  assign w_boundary = w_tick && (r_refresh == LAST_SLOT);

  // Slot index advances once per prescaler tick and wraps naturally 3 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_refresh <= '0;
    end else if (w_tick) begin
      r_refresh <= r_refresh + slot_idx_t'(1);
    end
  end

  // Double-buffered digit data: stage loads, commit at the frame boundary.
  // A load arriving in the boundary cycle itself goes straight to active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active        <= '0;
      r_pending       <= '0;
      r_pending_valid <= 1'b0;
      r_load_ack      <= 1'b0;
    end else begin
      r_load_ack <= 1'b0;
      if (w_boundary && load_req) begin
        r_active        <= digits_in;
        r_pending_valid <= 1'b0;
        r_load_ack      <= 1'b1;
      end else if (load_req) begin
        r_pending       <= digits_in;
        r_pending_valid <= 1'b1;
      end else if (w_boundary && r_pending_valid) begin
        r_active        <= r_pending;
        r_pending_valid <= 1'b0;
        r_load_ack      <= 1'b1;
      end
    end
  end

  // One-cycle frame marker following each boundary edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_boundary;
    end
  end

  assign refreshcounter = r_refresh;
  assign digit_out      = get_nibble(r_active, r_refresh);
  assign load_ack       = r_load_ack;
  assign frame_done     = r_frame_done;

`ifdef LEADING_ZERO_BLANK_EN
  // w_upper_zero[i] is set when nibble i and every higher nibble are zero.
  logic [NUM_DIGITS:0] w_upper_zero;
  assign w_upper_zero[NUM_DIGITS] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_zero_chain
      assign w_upper_zero[gi] = w_upper_zero[gi+1] &&
                                (r_active[gi*DIGIT_W +: DIGIT_W] == '0);
    end
  endgenerate

  // Digit 0 is always shown so a zero value still displays "0".
  assign blank = (r_refresh != '0) && w_upper_zero[{1'b0, r_refresh}];
`else
  assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_display_scan_sequencer.sv
// Directed testbench for display_scan_sequencer with PRESCALE=4.
// Edge numbering: edge 1 is the first posedge after reset release; outputs
// are sampled 1 ns after each posedge.
module tb_display_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] digits_in;
  logic        load_req;
  logic        load_ack;
  logic [1:0]  refreshcounter;
  logic [3:0]  digit_out;
  logic        blank;
  logic        frame_done;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic BLANK_ON = 1'b1;
`else
  localparam logic BLANK_ON = 1'b0;
`endif

  display_scan_sequencer #(.PRESCALE(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .digits_in      (digits_in),
    .load_req       (load_req),
    .load_ack       (load_ack),
    .refreshcounter (refreshcounter),
    .digit_out      (digit_out),
    .blank          (blank),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  task automatic step_to(input int t);
    while (edge_n < t) begin
      @(posedge clk);
      #1;
      edge_n++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b1; load_req = 1'b0; digits_in = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; load_req = 1'b0; digits_in = 16'hFFFF;
    @(posedge clk); #1;
    checks++; if (refreshcounter !== 2'd0) begin errors++; $display("FAIL reset_rc: got %0d exp 0", refreshcounter); end
    checks++; if (digit_out !== 4'd0) begin errors++; $display("FAIL reset_digit: got %0d exp 0", digit_out); end
    checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b exp 0", load_ack); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b exp 0", frame_done); end
    checks++; if (blank !== 1'b0) begin errors++; $display("FAIL reset_blank: got %b exp 0", blank); end
    $display("test_reset done");
  endtask

  task automatic test_scan();
    do_reset();
    for (int k = 1; k <= 32; k++) begin
      step_to(k);
      checks++; if (refreshcounter !== 2'((k / 4) % 4)) begin errors++; $display("FAIL scan_rc edge %0d: got %0d exp %0d", k, refreshcounter, (k / 4) % 4); end
      checks++; if (frame_done !== ((k == 16) || (k == 32))) begin errors++; $display("FAIL scan_fd edge %0d: got %b", k, frame_done); end
      checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL scan_noack edge %0d: got %b exp 0", k, load_ack); end
      checks++; if (digit_out !== 4'd0) begin errors++; $display("FAIL scan_digit edge %0d: got %h exp 0", k, digit_out); end
    end
    $display("test_scan done");
  endtask

  task automatic test_load();
    do_reset();
    step_to(5);
    checks++; if (refreshcounter !== 2'd1) begin errors++; $display("FAIL load_slot: got %0d exp 1", refreshcounter); end
    load_req = 1'b1; digits_in = 16'h1234;
    step_to(6);
    load_req = 1'b0; digits_in = 16'hFFFF;
    for (int k = 6; k <= 15; k++) begin
      step_to(k);
      checks++; if (digit_out !== 4'd0) begin errors++; $display("FAIL load_hold edge %0d: got %h exp 0", k, digit_out); end
      checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL load_early_ack edge %0d: got %b exp 0", k, load_ack); end
    end
    step_to(16);
    checks++; if (digit_out !== 4'h4) begin errors++; $display("FAIL load_d0: got %h exp 4", digit_out); end
    checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL load_ack: got %b exp 1", load_ack); end
    step_to(17);
    checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL load_ack_pulse: got %b exp 0", load_ack); end
    step_to(20);
    checks++; if (digit_out !== 4'h3) begin errors++; $display("FAIL load_d1: got %h exp 3", digit_out); end
    step_to(24);
    checks++; if (digit_out !== 4'h2) begin errors++; $display("FAIL load_d2: got %h exp 2", digit_out); end
    step_to(28);
    checks++; if (digit_out !== 4'h1) begin errors++; $display("FAIL load_d3: got %h exp 1", digit_out); end
    $display("test_load done");
  endtask

  task automatic test_last_wins();
    int acks = 0;
    do_reset();
    step_to(5);  load_req = 1'b1; digits_in = 16'h1111;
    step_to(6);  load_req = 1'b0;
    step_to(9);  load_req = 1'b1; digits_in = 16'h5678;
    step_to(10); load_req = 1'b0; digits_in = 16'h0;
    for (int k = 10; k <= 31; k++) begin
      step_to(k);
      if (load_ack === 1'b1) acks++;
      if (k == 16) begin
        checks++; if (digit_out !== 4'h8) begin errors++; $display("FAIL last_d0: got %h exp 8", digit_out); end
      end
      if (k == 20) begin
        checks++; if (digit_out !== 4'h7) begin errors++; $display("FAIL last_d1: got %h exp 7", digit_out); end
      end
    end
    checks++; if (acks !== 1) begin errors++; $display("FAIL last_ack_count: got %0d exp 1", acks); end
    $display("test_last_wins done");
  endtask

  task automatic test_bypass();
    int acks = 0;
    do_reset();
    step_to(5);  load_req = 1'b1; digits_in = 16'h1111;
    step_to(6);  load_req = 1'b0;
    step_to(15); load_req = 1'b1; digits_in = 16'h9876;
    step_to(16); load_req = 1'b0; digits_in = 16'h0;
    checks++; if (digit_out !== 4'h6) begin errors++; $display("FAIL bypass_d0: got %h exp 6", digit_out); end
    checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL bypass_ack: got %b exp 1", load_ack); end
    for (int k = 17; k <= 33; k++) begin
      step_to(k);
      if (load_ack === 1'b1) acks++;
      if (k == 20) begin
        checks++; if (digit_out !== 4'h7) begin errors++; $display("FAIL bypass_d1: got %h exp 7", digit_out); end
      end
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL bypass_noack: got %0d acks exp 0", acks); end
    $display("test_bypass done");
  endtask

  task automatic test_enable();
    do_reset();
    step_to(9);
    enable = 1'b0;
    for (int k = 10; k <= 19; k++) begin
      step_to(k);
      checks++; if (refreshcounter !== 2'd2) begin errors++; $display("FAIL en_hold edge %0d: got %0d exp 2", k, refreshcounter); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL en_fd edge %0d: got %b exp 0", k, frame_done); end
    end
    enable = 1'b1;
    step_to(22);
    checks++; if (refreshcounter !== 2'd2) begin errors++; $display("FAIL en_full_slot: got %0d exp 2", refreshcounter); end
    step_to(23);
    checks++; if (refreshcounter !== 2'd3) begin errors++; $display("FAIL en_resume: got %0d exp 3", refreshcounter); end
    step_to(26);
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL en_fd_early: got %b exp 0", frame_done); end
    step_to(27);
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL en_fd_wrap: got %b exp 1", frame_done); end
    checks++; if (refreshcounter !== 2'd0) begin errors++; $display("FAIL en_wrap_rc: got %0d exp 0", refreshcounter); end
    $display("test_enable done");
  endtask

  task automatic test_blank();
    do_reset();
    step_to(5); load_req = 1'b1; digits_in = 16'h0050;
    step_to(6); load_req = 1'b0; digits_in = 16'h0;
    step_to(16);
    checks++; if (blank !== 1'b0) begin errors++; $display("FAIL blank_s0: got %b exp 0", blank); end
    checks++; if (digit_out !== 4'h0) begin errors++; $display("FAIL blank_d0: got %h exp 0", digit_out); end
    step_to(20);
    checks++; if (blank !== 1'b0) begin errors++; $display("FAIL blank_s1: got %b exp 0", blank); end
    checks++; if (digit_out !== 4'h5) begin errors++; $display("FAIL blank_d1: got %h exp 5", digit_out); end
    step_to(24);
    checks++; if (blank !== BLANK_ON) begin errors++; $display("FAIL blank_s2: got %b exp %b", blank, BLANK_ON); end
    step_to(28);
    checks++; if (blank !== BLANK_ON) begin errors++; $display("FAIL blank_s3: got %b exp %b", blank, BLANK_ON); end
    $display("test_blank done");
  endtask

  task automatic test_reset_pending();
    int acks = 0;
    do_reset();
    step_to(5);  load_req = 1'b1; digits_in = 16'h4321;
    step_to(6);  load_req = 1'b0;
    step_to(28);
    checks++; if (digit_out !== 4'h4) begin errors++; $display("FAIL rstp_pre_d3: got %h exp 4", digit_out); end
    step_to(29); load_req = 1'b1; digits_in = 16'hABCD;
    step_to(30); load_req = 1'b0; digits_in = 16'h0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (refreshcounter !== 2'd0) begin errors++; $display("FAIL rstp_rc: got %0d exp 0", refreshcounter); end
    checks++; if (digit_out !== 4'd0) begin errors++; $display("FAIL rstp_digit: got %h exp 0", digit_out); end
    checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL rstp_ack: got %b exp 0", load_ack); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rstp_fd: got %b exp 0", frame_done); end
    checks++; if (blank !== 1'b0) begin errors++; $display("FAIL rstp_blank: got %b exp 0", blank); end
    @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;
    for (int k = 1; k <= 17; k++) begin
      step_to(k);
      if (load_ack === 1'b1) acks++;
      if (k == 3) begin
        checks++; if (refreshcounter !== 2'd0) begin errors++; $display("FAIL rstp_full_slot: got %0d exp 0", refreshcounter); end
      end
      if (k == 4) begin
        checks++; if (refreshcounter !== 2'd1) begin errors++; $display("FAIL rstp_slot1: got %0d exp 1", refreshcounter); end
      end
      if (k == 16) begin
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL rstp_fd_wrap: got %b exp 1", frame_done); end
        checks++; if (digit_out !== 4'd0) begin errors++; $display("FAIL rstp_d0: got %h exp 0", digit_out); end
      end
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL rstp_noack: got %0d acks exp 0", acks); end
    $display("test_reset_pending done");
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_last_wins();
    test_bypass();
    test_enable();
    test_blank();
    test_reset_pending();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_scan_sequencer.md
DISPLAY_SCAN_SEQUENCER -- requirements
Module: display_scan_sequencer

Interface
REQ-001: Parameter PRESCALE, default 100000, clk cycles per digit slot (1 kHz at 100 MHz); SHALL be >= 2.
REQ-002: clk  input  1  system clock; all state rises on posedge clk.
REQ-003: rst_n  input  1  asynchronous, active-low reset.
REQ-004: enable  input  1  scan run; low freezes the scan.
REQ-005: digits_in  input  16  four BCD nibbles; [3:0] is digit 0, [15:12] is digit 3.
REQ-006: load_req  input  1  single-cycle strobe; digits_in is valid in the same cycle.
REQ-007: load_ack  output  1  one-cycle pulse when loaded data becomes active.
REQ-008: refreshcounter  output  2  digit slot index for the anode controller.
REQ-009: digit_out  output  4  BCD nibble of the active digit for the 7-segment decoder.
REQ-010: blank  output  1  active digit is suppressed.
REQ-011: frame_done  output  1  one-cycle pulse at the end of the slot-3 to slot-0 wrap.

Function
REQ-012: Prescaler counts 0..PRESCALE-1 while enable=1; tick asserts in the cycle where count==PRESCALE-1, then count returns to 0.
REQ-013: enable=0 clears the prescaler to 0; refreshcounter, active data and outputs hold.
REQ-014: refreshcounter increments on the posedge after tick; it wraps 3->0.
REQ-015: Frame boundary is tick while refreshcounter==3.
REQ-016: load_req captures digits_in into a pending register and sets pending flag; a later load_req before the boundary overwrites it (last wins).
REQ-017: At a frame boundary with pending set, active register <= pending data and pending clears; load_ack pulses in the next cycle.
REQ-018: load_req in the boundary cycle itself bypasses pending: its digits_in becomes active at that edge, with load_ack the next cycle.
REQ-019: A boundary with no pending data leaves the active register unchanged and produces no load_ack.
REQ-020: digit_out = active nibble[refreshcounter], combinational from registered state, so it changes on the same edge as refreshcounter.
REQ-021: frame_done is registered and high for exactly the one cycle after each boundary edge.
REQ-022: load_req is accepted regardless of enable.

Reset
REQ-023: rst_n low: prescaler=0, refreshcounter=0, active=16'h0000, pending empty, load_ack=0, frame_done=0, blank=0.
REQ-024: Reset mid-frame discards pending data; after release, scanning restarts at slot 0 with a full PRESCALE interval.

Configuration
REQ-025: Macro LEADING_ZERO_BLANK_EN.
- Defined: blank=1 when the active nibble and all higher-index nibbles are zero; digit 0 is never blanked.
- Undefined: blank is constant 0.

Structure
REQ-026: Shared package display_pkg holds NUM_DIGITS=4, DIGIT_W=4 and the slot index type shared with the anode controller.
REQ-027: Prescaler is sub-module refresh_prescaler (ports clk, rst_n, enable, tick).

Verification
REQ-028: PRESCALE=4, enable=1 after reset -> refreshcounter steps 0,1,2,3,0 every 4 cycles; frame_done pulses every 16 cycles.
REQ-029: load 16'h1234 at slot 1 -> digit_out stays 0 until the boundary; load_ack one cycle after; slots 0..3 then show 4,3,2,1.
REQ-030: load 16'h1111 then 16'h5678 in the same frame -> only 5678 becomes active, with a single load_ack.
REQ-031: enable=0 for 10 cycles at slot 2 -> refreshcounter stays 2, no frame_done; resume gives a full 4-cycle slot.
REQ-032: LEADING_ZERO_BLANK_EN, active 16'h0050 -> blank=1 at slots 3 and 2, blank=0 at slots 1 and 0 (digit 0 shows 0).
REQ-033: rst_n low at slot 3 with load pending -> all outputs 0; after release, no load_ack occurs at the next boundary.
